// File: rtl/port_receive_arbiter_if.sv
// Handshake bundle between the per-port receive FIFOs, the arbiter and the orchestrator ingress.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface port_receive_arbiter_if #(
    parameter int unsigned NUMBER_OF_PORTS = 4
);
    localparam int unsigned PortWidth = $clog2(NUMBER_OF_PORTS);

    logic [NUMBER_OF_PORTS-1:0]   port_receive_data_valid;
    logic [NUMBER_OF_PORTS*9-1:0] port_receive_data;
    logic                         downstream_ready;
    logic [NUMBER_OF_PORTS-1:0]   port_receive_data_enable;
    logic [8:0]                   grant_data;
    logic                         grant_data_valid;
    logic [PortWidth-1:0]         grant_port;
    logic                         frame_start;
    logic                         frame_done;
    logic [15:0]                  frame_byte_count;
    logic                         frame_error;

    modport master (
        output port_receive_data_valid,
        output port_receive_data,
        output downstream_ready,
        input  port_receive_data_enable,
        input  grant_data,
        input  grant_data_valid,
        input  grant_port,
        input  frame_start,
        input  frame_done,
        input  frame_byte_count,
        input  frame_error
    );

    modport slave (
        input  port_receive_data_valid,
        input  port_receive_data,
        input  downstream_ready,
        output port_receive_data_enable,
        output grant_data,
        output grant_data_valid,
        output grant_port,
        output frame_start,
        output frame_done,
        output frame_byte_count,
        output frame_error
    );
endinterface

// File: rtl/port_receive_arbiter.sv
// Frame-level round-robin arbiter: grants one port per frame and forwards its beats as a
// registered stream, reporting frame length and timeout / length cut-off terminations.
module port_receive_arbiter #(
    parameter int unsigned NUMBER_OF_PORTS = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned MAX_FRAME_BYTES = 1522
) (
    input logic                   clock,
    input logic                   reset,
    port_receive_arbiter_if.slave bus
);
    localparam int unsigned PortWidth = $clog2(NUMBER_OF_PORTS);
    localparam int unsigned IdleWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PortWidth-1:0] LastPort  = PortWidth'(NUMBER_OF_PORTS - 1);
    localparam logic [15:0]          MaxBeats  = 16'(MAX_FRAME_BYTES);
    localparam logic [IdleWidth-1:0] IdleLimit = IdleWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StTransfer, StClose} state_e;

    state_e               state_q, state_d;
    logic [PortWidth-1:0] last_grant_q, last_grant_d;
    logic [PortWidth-1:0] grant_port_q, grant_port_d;
    logic [15:0]          beat_count_q, beat_count_d;
    logic [IdleWidth-1:0] idle_count_q, idle_count_d;
    logic [8:0]           grant_data_q, grant_data_d;
    logic                 grant_data_valid_q, grant_data_valid_d;
    logic                 frame_start_q, frame_start_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_byte_count_q, frame_byte_count_d;
    logic                 frame_error_q, frame_error_d;

    logic [8:0]           port_beat [NUMBER_OF_PORTS];
    logic [8:0]           granted_beat;
    logic                 pop;
    logic [15:0]          beat_next;
    logic                 rr_hit;
    logic [PortWidth-1:0] rr_winner;
    int unsigned          candidate;

    for (genvar g = 0; g < NUMBER_OF_PORTS; g++) begin : gen_unpack
        assign port_beat[g] = bus.port_receive_data[g*9 +: 9];
    end

    // First requester found walking upward from the port after the last owner.
    always_comb begin
        rr_hit    = 1'b0;
        rr_winner = '0;
        candidate = 0;
        for (int unsigned k = 1; k <= NUMBER_OF_PORTS; k++) begin
            candidate = (int'(last_grant_q) + k) % NUMBER_OF_PORTS;
            if (!rr_hit && bus.port_receive_data_valid[PortWidth'(candidate)]) begin
                rr_hit    = 1'b1;
                rr_winner = PortWidth'(candidate);
            end
        end
    end

    assign granted_beat = port_beat[grant_port_q];
    assign pop = (state_q == StTransfer) && bus.port_receive_data_valid[grant_port_q]
                 && bus.downstream_ready;
    assign beat_next = (beat_count_q == 16'hFFFF) ? beat_count_q : beat_count_q + 16'd1;

    always_comb begin
        bus.port_receive_data_enable               = '0;
        bus.port_receive_data_enable[grant_port_q] = pop;
    end

    always_comb begin
        state_d            = state_q;
        last_grant_d       = last_grant_q;
        grant_port_d       = grant_port_q;
        beat_count_d       = beat_count_q;
        idle_count_d       = idle_count_q;
        grant_data_d       = grant_data_q;
        grant_data_valid_d = 1'b0;
        frame_start_d      = 1'b0;
        frame_done_d       = 1'b0;
        frame_byte_count_d = frame_byte_count_q;
        frame_error_d      = frame_error_q;

        unique case (state_q)
            StIdle: begin
                if (rr_hit) begin
                    grant_port_d = rr_winner;
                    beat_count_d = '0;
                    idle_count_d = '0;
                    state_d      = StTransfer;
                end
            end
            StTransfer: begin
                if (pop) begin
                    beat_count_d       = beat_next;
                    idle_count_d       = '0;
                    grant_data_valid_d = 1'b1;
                    grant_data_d       = granted_beat;
                    frame_start_d      = (beat_count_q == 16'd0);
                    if (granted_beat[8] || beat_next == MaxBeats) begin
                        // A cut-off beat is forced to look like an end marker downstream.
                        grant_data_d[8]    = 1'b1;
                        frame_done_d       = 1'b1;
                        frame_byte_count_d = beat_next;
                        frame_error_d      = !granted_beat[8];
                        state_d            = StClose;
                    end
                end else if (idle_count_q == IdleLimit) begin
                    frame_done_d       = 1'b1;
                    frame_byte_count_d = beat_count_q;
                    frame_error_d      = 1'b1;
                    state_d            = StClose;
                end else begin
                    idle_count_d = idle_count_q + IdleWidth'(1);
                end
            end
            StClose: begin
                last_grant_d = grant_port_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= StIdle;
            last_grant_q       <= LastPort;
            grant_port_q       <= '0;
            beat_count_q       <= '0;
            idle_count_q       <= '0;
            grant_data_q       <= '0;
            grant_data_valid_q <= 1'b0;
            frame_start_q      <= 1'b0;
            frame_done_q       <= 1'b0;
            frame_byte_count_q <= '0;
            frame_error_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_q       <= last_grant_d;
            grant_port_q       <= grant_port_d;
            beat_count_q       <= beat_count_d;
            idle_count_q       <= idle_count_d;
            grant_data_q       <= grant_data_d;
            grant_data_valid_q <= grant_data_valid_d;
            frame_start_q      <= frame_start_d;
            frame_done_q       <= frame_done_d;
            frame_byte_count_q <= frame_byte_count_d;
            frame_error_q      <= frame_error_d;
        end
    end

    assign bus.grant_data       = grant_data_q;
    assign bus.grant_data_valid = grant_data_valid_q;
    assign bus.grant_port       = grant_port_q;
    assign bus.frame_start      = frame_start_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.frame_byte_count = frame_byte_count_q;
    assign bus.frame_error      = frame_error_q;
endmodule

// File: tb/tb_port_receive_arbiter.sv
// Bench for port_receive_arbiter: per-port beat queues feed the DUT and a frame-level
// reference model predicts the pop strobes and every registered output each cycle.
module tb_port_receive_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam int MAXB    = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    port_receive_arbiter_if #(.NUMBER_OF_PORTS(N)) bus ();

    port_receive_arbiter #(
        .NUMBER_OF_PORTS(N),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_FRAME_BYTES(MAXB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [8:0] q [N][$];
    logic [8:0] sent [$];
    bit         hold [N];
    bit         ready;

    // Reference model: who owns the path, whether the frame is closing, counters.
    int  m_owner;
    bit  m_closing;
    int  m_last, m_cnt, m_idle;
    logic [8:0] e_gd;
    bit  e_gdv, e_fs, e_fd, e_err;
    int  e_cnt, e_gp;

    // Observations of the DUT, for scenario-level checks.
    int         grants [$];
    int         starts [$];
    logic [8:0] fwd [$];
    logic [16:0] dones [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("grant_data_valid", 32'(bus.grant_data_valid), 32'(e_gdv));
        check("grant_data", 32'(bus.grant_data), 32'(e_gd));
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("frame_byte_count", 32'(bus.frame_byte_count), 32'(e_cnt));
        check("frame_error", 32'(bus.frame_error), 32'(e_err));
        check("grant_port", 32'(bus.grant_port), 32'(e_gp));
    endtask

    task automatic model_reset();
        m_owner = -1; m_closing = 0; m_last = N - 1; m_cnt = 0; m_idle = 0;
        e_gd = '0; e_gdv = 0; e_fs = 0; e_fd = 0; e_err = 0; e_cnt = 0; e_gp = 0;
    endtask

    task automatic push_frame(input int p, input int len, input bit eof);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b[7:0] = 8'($urandom_range(0, 255));
            b[8]   = eof && (i == len - 1);
            q[p].push_back(b);
            sent.push_back(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.port_receive_data_valid = '0;
        bus.port_receive_data = '0;
        bus.downstream_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        cyc++;
        for (int p = 0; p < N; p++) begin
            q[p].delete();
            hold[p] = 0;
        end
        sent.delete(); grants.delete(); starts.delete(); fwd.delete(); dones.delete();
        model_reset();
        check_outputs();
        check("enable_after_reset", 32'(bus.port_receive_data_enable), 32'd0);
    endtask

    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] exp_en;
        bit           pop;
        logic [8:0]   beat;
        bit           found;
        int           p;
        for (int i = 0; i < N; i++) begin
            v[i] = (q[i].size() != 0) && !hold[i];
            bus.port_receive_data[i*9 +: 9] = v[i] ? q[i][0] : 9'h0;
        end
        bus.port_receive_data_valid = v;
        bus.downstream_ready = ready;
        #1;
        exp_en = '0;
        pop = 0;
        if (m_owner >= 0 && !m_closing && v[m_owner] && ready) begin
            pop = 1;
            exp_en[m_owner] = 1'b1;
        end
        check("enable", 32'(bus.port_receive_data_enable), 32'(exp_en));
        @(posedge clock); #1;
        cyc++;
        e_gdv = 0; e_fs = 0; e_fd = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (!found && v[p]) begin
                    found = 1; m_owner = p; e_gp = p; m_cnt = 0; m_idle = 0;
                end
            end
        end else if (m_closing) begin
            m_last = m_owner; m_owner = -1; m_closing = 0;
        end else if (pop) begin
            beat = q[m_owner].pop_front();
            if (m_cnt < 65535) m_cnt++;
            m_idle = 0;
            e_gdv = 1; e_fs = (m_cnt == 1); e_gd = beat;
            if (beat[8] || m_cnt == MAXB) begin
                e_gd[8] = 1'b1; e_fd = 1; e_cnt = m_cnt; e_err = !beat[8]; m_closing = 1;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e_fd = 1; e_cnt = m_cnt; e_err = 1; m_closing = 1;
            end
        end
        check_outputs();
        if (bus.frame_start) begin
            grants.push_back(int'(bus.grant_port));
            starts.push_back(cyc);
        end
        if (bus.grant_data_valid) fwd.push_back(bus.grant_data);
        if (bus.frame_done) dones.push_back({bus.frame_error, bus.frame_byte_count});
    endtask

    task automatic run(input int n, input bit rdy);
        ready = rdy;
        repeat (n) step();
    endtask

    initial begin
        int p;
        model_reset();
        ready = 1'b0;

        // Single frame from port 2.
        do_reset();
        push_frame(2, 5, 1);
        run(10, 1);
        check("single_grant", 32'((grants.size() > 0) ? grants[0] : 99), 32'd2);
        check("single_beats", 32'(fwd.size()), 32'd5);
        check("single_done", 32'((dones.size() > 0) ? dones[0] : 17'h1FFFF), {15'd0, 1'b0, 16'd5});

        // Round robin with continuous requests.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_frame(i, 3, 1);
        run(45, 1);
        for (int i = 0; i < 5; i++)
            check("rr_order", 32'((grants.size() > i) ? grants[i] : 99), 32'(i % N));
        for (int i = 0; i < 4; i++)
            check("rr_gap", 32'((starts.size() > i + 1) ? starts[i+1] - starts[i] : 0), 32'd5);

        // Backpressure mid-frame.
        do_reset();
        push_frame(1, 8, 1);
        run(3, 1);
        run(4, 0);
        run(10, 1);
        check("bp_count", 32'(fwd.size()), 32'(sent.size()));
        for (int i = 0; i < 8; i++)
            check("bp_data", 32'((fwd.size() > i) ? fwd[i] : 9'h0), 32'(sent[i]));

        // Timeout: port 1 stalls after 3 beats, port 3 should follow.
        do_reset();
        push_frame(1, 3, 0);
        run(1, 1);
        push_frame(3, 3, 1);
        push_frame(0, 3, 1);
        run(30, 1);
        check("to_done", 32'((dones.size() > 0) ? dones[0] : 17'h0), {15'd0, 1'b1, 16'd3});
        check("to_next", 32'((grants.size() > 1) ? grants[1] : 99), 32'd3);

        // Length cut-off on port 0.
        do_reset();
        push_frame(0, 20, 0);
        run(45, 1);
        check("cut_beat16", 32'((fwd.size() > 15) ? fwd[15] : 9'h0), 32'({1'b1, sent[15][7:0]}));
        check("cut_done", 32'((dones.size() > 0) ? dones[0] : 17'h0), {15'd0, 1'b1, 16'd16});
        check("cut_rest", 32'((dones.size() > 1) ? dones[1] : 17'h0), {15'd0, 1'b1, 16'd4});

        // Reset in the middle of a port 3 frame.
        do_reset();
        push_frame(3, 6, 1);
        run(3, 1);
        do_reset();
        for (int i = 0; i < N; i++) push_frame(i, 2, 1);
        run(10, 1);
        check("rst_first_grant", 32'((grants.size() > 0) ? grants[0] : 99), 32'd0);

        // Randomized traffic, stalls and backpressure.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                p = int'($urandom_range(0, N - 1));
                if (q[p].size() < 40)
                    push_frame(p, int'($urandom_range(1, 24)), $urandom_range(0, 6) != 0);
            end
            for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
